memoria_ram_param: RTL and testbench

- Parametrised single-clock synchronous RAM; successor to the fixed 2Kx8 read-only block-RAM lookup.
- Adds a write port, configurable width and depth, and an optional output register.
- Adds a read-valid strobe and a hardware clear engine that fills the array with a constant after reset or on request.
- Sits between datapath logic and inferred block RAM; replaces hand-instantiated primitives in the memory subsystem.

---
 rtl/memoria_pkg.sv | 15 +
 rtl/memoria_ram_core.sv | 23 ++
 rtl/memoria_ram_param.sv | 136 +++++++++++++
 tb/tb_memoria_ram_param.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/memoria_pkg.sv
// Shared definitions for the parametrised RAM block.
// State encoding and default parameter values.
package memoria_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 11;
  localparam int DEF_OUT_REG    = 0;
  localparam int DEF_CLR_ON_RST = 1;

endpackage

// File: rtl/memoria_ram_core.sv
// Reset-free inferable RAM array, one write and one read port.
// Read-first on address collision, registered read data.
module memoria_ram_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/memoria_ram_param.sv
// Parametrised synchronous RAM with clear engine,
// optional output register and read-valid strobe.
module memoria_ram_param
  import memoria_pkg::*;
#(
  parameter int              DATA_W     = DEF_DATA_W,
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter int              OUT_REG    = DEF_OUT_REG,
  parameter logic [DATA_W-1:0] CLR_VAL  = '0,
  parameter int              CLR_ON_RST = DEF_CLR_ON_RST
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              iclear,
  input  logic              iwe,
  input  logic [ADDR_W-1:0] ivwaddr,
  input  logic [DATA_W-1:0] ivwdata,
  input  logic              ire,
  input  logic [ADDR_W-1:0] ivraddr,
  output logic [DATA_W-1:0] ovrdata,
  output logic              ovalid,
  output logic              obusy
);

  localparam state_t RST_ST =
    (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  logic              accept;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_re;
  logic [DATA_W-1:0] core_q;
  logic              v1_q;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      state_q <= RST_ST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (iclear) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == '1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The edge that accepts iclear also drops user traffic.
  always_comb begin
    obusy     = (state_q == ST_CLEAR);
    accept    = !obusy && !iclear;
    mem_we    = 1'b0;
    mem_waddr = ivwaddr;
    mem_wdata = ivwdata;
    mem_re    = 1'b0;
    unique case (1'b1)
      obusy: begin
        mem_we    = !irst;
        mem_waddr = cnt_q;
        mem_wdata = CLR_VAL;
      end
      default: begin
        mem_we = iwe && accept && !irst;
        mem_re = ire && accept && !irst;
      end
    endcase
  end

  memoria_ram_core #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_core (
    .clk  (iclk),
    .we   (mem_we),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (mem_re),
    .raddr(ivraddr),
    .rdata(core_q)
  );

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) v1_q <= 1'b0;
    else      v1_q <= mem_re;
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              v2_q;
      logic [DATA_W-1:0] dq_q;

      always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
          v2_q <= 1'b0;
          dq_q <= '0;
        end else begin
          v2_q <= v1_q;
          if (v1_q) dq_q <= core_q;
        end
      end

      assign ovalid  = v2_q;
      assign ovrdata = dq_q;
    end else begin : g_noreg
      // Core register has no reset; mask it until a read lands.
      logic seen_q;

      always_ff @(posedge iclk or posedge irst) begin
        if (irst)        seen_q <= 1'b0;
        else if (mem_re) seen_q <= 1'b1;
      end

      assign ovalid  = v1_q;
      assign ovrdata = seen_q ? core_q : '0;
    end
  endgenerate

endmodule

// File: tb/tb_memoria_ram_param.sv
// Scoreboard bench for memoria_ram_param, OUT_REG=0 and 1
// instances driven in parallel.
module tb_memoria_ram_param;

  typedef struct packed {
    logic [7:0]  d;
    logic [31:0] c;
  } exp_t;

  logic       iclk = 1'b0;
  logic       irst = 1'b1;
  logic       iclear = 1'b0;
  logic       iwe = 1'b0;
  logic [3:0] ivwaddr = '0;
  logic [7:0] ivwdata = '0;
  logic       ire = 1'b0;
  logic [3:0] ivraddr = '0;
  logic [7:0] ovrdata0, ovrdata1;
  logic       ovalid0, ovalid1;
  logic       obusy0, obusy1;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] mdl [16];
  logic [7:0] last [2];

  always #5 iclk = ~iclk;
  always @(posedge iclk) cyc <= cyc + 1;

  memoria_ram_param #(
    .DATA_W(8), .ADDR_W(4), .OUT_REG(0),
    .CLR_VAL(8'hA5), .CLR_ON_RST(1)
  ) dut0 (
    .iclk(iclk), .irst(irst), .iclear(iclear),
    .iwe(iwe), .ivwaddr(ivwaddr), .ivwdata(ivwdata),
    .ire(ire), .ivraddr(ivraddr),
    .ovrdata(ovrdata0), .ovalid(ovalid0), .obusy(obusy0)
  );

  memoria_ram_param #(
    .DATA_W(8), .ADDR_W(4), .OUT_REG(1),
    .CLR_VAL(8'hA5), .CLR_ON_RST(1)
  ) dut1 (
    .iclk(iclk), .irst(irst), .iclear(iclear),
    .iwe(iwe), .ivwaddr(ivwaddr), .ivwdata(ivwdata),
    .ire(ire), .ivraddr(ivraddr),
    .ovrdata(ovrdata1), .ovalid(ovalid1), .obusy(obusy1)
  );

  task automatic chk(input string n, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic mon(input int p, input logic v,
                     input logic [7:0] d);
    exp_t e;
    if (irst) begin
      last[p] = '0;
      return;
    end
    if (v) begin
      if ((p == 0 && q0.size() == 0) ||
          (p == 1 && q1.size() == 0)) begin
        chk($sformatf("unexp_valid%0d", p), 1, 0);
      end else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("rdata%0d", p), int'(d), int'(e.d));
        chk($sformatf("lat%0d", p), cyc, int'(e.c));
      end
      last[p] = d;
    end else begin
      chk($sformatf("hold%0d", p), int'(d), int'(last[p]));
    end
  endtask

  always @(negedge iclk) begin
    mon(0, ovalid0, ovrdata0);
    mon(1, ovalid1, ovrdata1);
  end

  // Drive one cycle of traffic; read-first model update.
  task automatic op(input logic we, input logic [3:0] wa,
                    input logic [7:0] wd, input logic re,
                    input logic [3:0] ra);
    iwe = we; ivwaddr = wa; ivwdata = wd;
    ire = re; ivraddr = ra;
    if (re) begin
      q0.push_back('{d: mdl[ra], c: 32'(cyc + 1)});
      q1.push_back('{d: mdl[ra], c: 32'(cyc + 2)});
    end
    if (we) mdl[wa] = wd;
    @(negedge iclk);
  endtask

  task automatic idle();
    iwe = 1'b0; ire = 1'b0; iclear = 1'b0;
    @(negedge iclk);
  endtask

  task automatic count_busy(input bit hold, input bit pulse,
                            output int n0, output int n1);
    n0 = 0; n1 = 0;
    for (int k = 0; k < 40; k++) begin
      if (obusy0) n0++;
      if (obusy1) n1++;
      if (!obusy0 && !obusy1) begin
        iwe = 1'b0; ire = 1'b0; iclear = 1'b0;
        break;
      end
      iwe = hold; ire = hold;
      ivwaddr = 4'(k); ivraddr = 4'(k);
      ivwdata = 8'(k * 7 + 1);
      iclear = pulse & k[0];
      @(negedge iclk);
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) op(0, 0, 0, 1, 4'(a));
    idle();
  endtask

  task automatic set_clr();
    for (int a = 0; a < 16; a++) mdl[a] = 8'hA5;
  endtask

  int n0, n1;

  initial begin
    repeat (3) @(negedge iclk);
    chk("rst_rdata0", int'(ovrdata0), 0);
    chk("rst_rdata1", int'(ovrdata1), 0);
    chk("rst_valid0", int'(ovalid0), 0);
    chk("rst_valid1", int'(ovalid1), 0);
    chk("rst_busy0", int'(obusy0), 1);
    chk("rst_busy1", int'(obusy1), 1);
    #2 irst = 1'b0;
    set_clr();
    count_busy(0, 0, n0, n1);
    chk("busy_len0", n0, 16);
    chk("busy_len1", n1, 16);
    read_all();

    op(1, 4'd7, 8'h3C, 0, 0);
    op(0, 0, 0, 1, 4'd7);
    idle();

    op(1, 4'd2, 8'h11, 0, 0);
    op(1, 4'd2, 8'h22, 1, 4'd2);
    op(0, 0, 0, 1, 4'd2);
    idle();

    for (int a = 0; a < 4; a++) op(1, 4'(a), 8'(a), 0, 0);
    for (int a = 0; a < 4; a++) op(0, 0, 0, 1, 4'(a));
    idle();

    op(0, 0, 0, 1, 4'd7);
    iclear = 1'b1; iwe = 1'b1; ire = 1'b1;
    ivwaddr = 4'd7; ivwdata = 8'hFF; ivraddr = 4'd7;
    @(negedge iclk);
    iclear = 1'b0;
    count_busy(1, 0, n0, n1);
    chk("clr_len0", n0, 16);
    chk("clr_len1", n1, 16);
    set_clr();
    read_all();

    op(1, 4'd10, 8'h77, 0, 0);
    op(1, 4'd15, 8'h99, 0, 0);
    op(1, 4'd0, 8'h5A, 0, 0);
    idle();
    iclear = 1'b1;
    @(negedge iclk);
    iclear = 1'b0;
    repeat (5) @(negedge iclk);
    #2 irst = 1'b1;
    #1;
    chk("mid_rst_rdata0", int'(ovrdata0), 0);
    chk("mid_rst_rdata1", int'(ovrdata1), 0);
    chk("mid_rst_valid1", int'(ovalid1), 0);
    chk("mid_rst_busy0", int'(obusy0), 1);
    @(negedge iclk);
    #2 irst = 1'b0;
    count_busy(0, 1, n0, n1);
    chk("rst_clr_len0", n0, 16);
    chk("rst_clr_len1", n1, 16);
    set_clr();
    read_all();

    for (int k = 0; k < 10; k++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(negedge iclk);
    end
    chk("drain", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
